// File: rtl/rx_handoff_ctrl.sv
// rx_handoff_ctrl: buffers received UART bytes in a small circular FIFO and hands
// them to the CPU one at a time through a 4-phase ready/acknowledge handshake.
module rx_handoff_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic                   uart_valid,
    input  logic [7:0]             uart_data,
    input  logic                   uart_parity_err,
    input  logic                   cpu_ack,
    output logic [7:0]             cpu_data,
    output logic                   cpu_parity,
    output logic                   cpu_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             overflow_cnt,
    output logic [7:0]             perr_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PRESENT, WAIT_REL} state_t;

    state_t        state;
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          pop;
    logic          push;

    // The head stays in the FIFO while presented; it leaves only when the CPU acknowledges.
    assign pop  = (state == PRESENT) && cpu_ack;
    assign push = uart_valid && ((fifo_level < FULL_LEVEL) || pop);

    always_ff @(posedge clk_clk) begin
        if (push && !reset_reset) begin
            mem[wr_ptr] <= {uart_parity_err, uart_data};
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_level   <= '0;
            overflow_cnt <= '0;
            perr_cnt     <= '0;
            cpu_data     <= '0;
            cpu_parity   <= 1'b0;
            cpu_ready    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase

            if (uart_valid && !push && (overflow_cnt != 8'hFF)) begin
                overflow_cnt <= overflow_cnt + 8'd1;
            end
            if (push && uart_parity_err && (perr_cnt != 8'hFF)) begin
                perr_cnt <= perr_cnt + 8'd1;
            end

            // A stale acknowledge left high keeps the FSM in IDLE until the CPU releases it.
            case (state)
                IDLE: begin
                    if ((fifo_level != '0) && !cpu_ack) begin
                        state                  <= PRESENT;
                        {cpu_parity, cpu_data} <= mem[rd_ptr];
                        cpu_ready              <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (cpu_ack) begin
                        state     <= WAIT_REL;
                        cpu_ready <= 1'b0;
                    end
                end
                WAIT_REL: begin
                    if (!cpu_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cpu_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rx_handoff_ctrl.sv
// tb_rx_handoff_ctrl: scoreboard bench; accepted bytes are queued when driven and
// compared when the DUT presents them, with a reference model of level, FSM and counters.
module tb_rx_handoff_ctrl;
    localparam int DEPTH = 4;

    typedef enum {M_IDLE, M_PRESENT, M_WAIT} mstate_t;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic       uart_valid;
    logic [7:0] uart_data;
    logic       uart_parity_err;
    logic       cpu_ack;
    logic [7:0] cpu_data;
    logic       cpu_parity;
    logic       cpu_ready;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [7:0] overflow_cnt;
    logic [7:0] perr_cnt;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];
    mstate_t    m_state;
    int         m_level;
    int         m_ovf;
    int         m_perr;
    logic [7:0] m_data;
    logic       m_par;

    rx_handoff_ctrl #(.DEPTH(DEPTH)) dut (
        .clk_clk        (clk_clk),
        .reset_reset    (reset_reset),
        .uart_valid     (uart_valid),
        .uart_data      (uart_data),
        .uart_parity_err(uart_parity_err),
        .cpu_ack        (cpu_ack),
        .cpu_data       (cpu_data),
        .cpu_parity     (cpu_parity),
        .cpu_ready      (cpu_ready),
        .fifo_level     (fifo_level),
        .overflow_cnt   (overflow_cnt),
        .perr_cnt       (perr_cnt)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock: drive inputs, advance the reference model, then check every output after the edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic pe,
                                 input logic ack, input logic rst);
        logic       pop;
        logic       acc;
        logic       enter;
        logic [8:0] head;
        reset_reset     = rst;
        uart_valid      = v;
        uart_data       = d;
        uart_parity_err = pe;
        cpu_ack         = ack;
        enter           = 1'b0;
        head            = '0;
        if (rst) begin
            exp_q.delete();
            m_state = M_IDLE;
            m_level = 0;
            m_ovf   = 0;
            m_perr  = 0;
            m_data  = 8'h00;
            m_par   = 1'b0;
        end else begin
            pop = (m_state == M_PRESENT) && ack;
            acc = v && ((m_level < DEPTH) || pop);
            case (m_state)
                M_IDLE: if (m_level > 0 && !ack) begin
                    enter   = 1'b1;
                    head    = exp_q.pop_front();
                    m_state = M_PRESENT;
                end
                M_PRESENT: if (ack) m_state = M_WAIT;
                M_WAIT:    if (!ack) m_state = M_IDLE;
                default:   m_state = M_IDLE;
            endcase
            if (pop) m_level--;
            if (acc) begin
                exp_q.push_back({pe, d});
                m_level++;
                if (pe && m_perr != 255) m_perr++;
            end else if (v && m_ovf != 255) begin
                m_ovf++;
            end
        end
        @(posedge clk_clk);
        #1;
        uart_valid = 1'b0;
        if (enter) begin
            checkOutput("present_data", {24'd0, cpu_data}, {24'd0, head[7:0]});
            checkOutput("present_parity", {31'd0, cpu_parity}, {31'd0, head[8]});
            m_data = head[7:0];
            m_par  = head[8];
        end else begin
            checkOutput("cpu_data_hold", {24'd0, cpu_data}, {24'd0, m_data});
            checkOutput("cpu_parity_hold", {31'd0, cpu_parity}, {31'd0, m_par});
        end
        checkOutput("cpu_ready", {31'd0, cpu_ready}, {31'd0, m_state == M_PRESENT});
        checkOutput("fifo_level", {29'd0, fifo_level}, m_level);
        checkOutput("overflow_cnt", {24'd0, overflow_cnt}, m_ovf);
        checkOutput("perr_cnt", {24'd0, perr_cnt}, m_perr);
    endtask

    task automatic idleCycles(input int n, input logic ack);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, ack, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 * DEPTH && (m_level > 0 || m_state != M_IDLE); i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, m_state == M_PRESENT, 1'b0);
        end
        checkOutput("drained", m_level, 0);
    endtask

    initial begin
        reset_reset     = 1'b1;
        uart_valid      = 1'b0;
        uart_data       = 8'h00;
        uart_parity_err = 1'b0;
        cpu_ack         = 1'b0;

        // Reset with stray valid and a high acknowledge; all outputs must be zero.
        applyStimulus(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Single byte: ready two edges after the push, then a full handshake.
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("latency_ready", {31'd0, cpu_ready}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idleCycles(2, 1'b0);

        // Ordering: three back-to-back pushes, then three handshakes.
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
        checkOutput("order_level3", {29'd0, fifo_level}, 32'd3);
        drain();

        // Overflow: six pushes into an idle CPU keep four and drop two.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_level", {29'd0, fifo_level}, 32'd4);
        checkOutput("ovf_count", {24'd0, overflow_cnt}, 32'd2);
        drain();

        // Full FIFO with a push on the same edge the CPU acknowledges.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        checkOutput("full_pop_level", {29'd0, fifo_level}, 32'd4);
        checkOutput("full_pop_ovf", {24'd0, overflow_cnt}, 32'd2);
        drain();

        // Parity saturation: 300 parity-error bytes while the CPU drains continuously.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 8'($urandom_range(0, 255)), 1'b1, m_state == M_PRESENT, 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b0, m_state == M_PRESENT, 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b0, m_state == M_PRESENT, 1'b0);
        end
        drain();
        checkOutput("perr_saturated", {24'd0, perr_cnt}, 32'd255);

        // Reset in WAIT_REL with two bytes queued, acknowledge held high throughout.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("wait_rel_level", {29'd0, fifo_level}, 32'd2);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
        checkOutput("rst_level", {29'd0, fifo_level}, 32'd0);
        checkOutput("rst_data", {24'd0, cpu_data}, 32'd0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("stale_ack_ready", {31'd0, cpu_ready}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("restart_data", {24'd0, cpu_data}, 32'h5A);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rx_handoff_ctrl.md
RX_HANDOFF_CTRL -- requirements
Module: rx_handoff_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; a power of 2, minimum 2.
REQ-002 SHALL have port clk_clk  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_reset  in  1  synchronous reset, active-high.
REQ-004 SHALL have port uart_valid  in  1  one-cycle strobe: received byte available.
REQ-005 SHALL have port uart_data  in  8  received byte, qualified by uart_valid.
REQ-006 SHALL have port uart_parity_err  in  1  parity check failed for this byte, qualified by uart_valid.
REQ-007 SHALL have port cpu_ack  in  1  CPU read acknowledge level (driven from the Nios rx_read output PIO).
REQ-008 SHALL have port cpu_data  out  8  presented byte (to the rs232_rx PIO).
REQ-009 SHALL have port cpu_parity  out  1  parity-error flag of the presented byte (to the rx_parity PIO).
REQ-010 SHALL have port cpu_ready  out  1  presented byte valid (to the rx_read input PIO).
REQ-011 SHALL have port fifo_level  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port overflow_cnt  out  8  count of dropped bytes, saturating.
REQ-013 SHALL have port perr_cnt  out  8  count of accepted bytes with parity error, saturating.

Function
REQ-014 SHALL buffer {uart_parity_err, uart_data} (9 bits) in a DEPTH-entry circular FIFO with wrapping read/write pointers.
REQ-015 SHALL push when uart_valid=1 and (fifo_level<DEPTH or a pop occurs in the same cycle).
REQ-016 SHALL drop the byte when uart_valid=1, FIFO full and no same-cycle pop; overflow_cnt increments, saturating at 255.
REQ-017 SHALL increment perr_cnt, saturating at 255, on every accepted push with uart_parity_err=1; a dropped byte SHALL NOT count.
REQ-018 SHALL keep fifo_level unchanged on a simultaneous push and pop.
REQ-019 SHALL implement a 4-phase CPU handshake FSM with states IDLE, PRESENT and WAIT_REL.
REQ-020 IDLE SHALL go to PRESENT when fifo_level>0 and cpu_ack=0. On that edge, cpu_data and cpu_parity SHALL load from the FIFO head and cpu_ready SHALL go to 1.
REQ-021 IDLE with cpu_ack=1 (stale acknowledge) SHALL stay in IDLE.
REQ-022 PRESENT SHALL go to WAIT_REL when cpu_ack=1. On that edge, the FIFO head SHALL pop and cpu_ready SHALL go to 0.
REQ-023 WAIT_REL SHALL go to IDLE when cpu_ack=0.
REQ-024 cpu_data and cpu_parity SHALL be registered and SHALL hold their value from PRESENT entry until the next PRESENT entry.
REQ-025 Latency: with the FSM in IDLE, cpu_ack=0 and an empty FIFO, uart_valid sampled at edge k SHALL give cpu_ready=1 after edge k+1.
REQ-026 Each byte SHALL be presented exactly once, in arrival order; no byte SHALL be popped without a cpu_ack rising phase in PRESENT.

Reset
REQ-027 While reset_reset=1 at a clock edge, the block SHALL clear FIFO pointers, fifo_level, overflow_cnt, perr_cnt, cpu_data, cpu_parity and cpu_ready to 0 and set the FSM to IDLE.
REQ-028 A reset mid-handshake SHALL discard all buffered bytes.
REQ-029 After reset, a cpu_ack still high SHALL be treated per REQ-021.
REQ-030 uart_valid SHALL be ignored during reset.

Verification
REQ-031 Single byte: push 0xA5 with perr=0, hold cpu_ack=0 -> cpu_ready=1 two edges later, cpu_data=0xA5, cpu_parity=0; raise cpu_ack -> cpu_ready=0, fifo_level=0; drop cpu_ack -> IDLE.
REQ-032 Ordering: push 0x01, 0x02, 0x03 back-to-back, then run three full handshakes -> presented sequence is 0x01, 0x02, 0x03; fifo_level goes 3,2,1,0.
REQ-033 Overflow: DEPTH=4, CPU idle, push 6 bytes -> fifo_level=4, overflow_cnt=2; drain -> first 4 bytes only.
REQ-034 Full plus simultaneous pop: FIFO full, push on the same edge cpu_ack rises in PRESENT -> byte accepted, fifo_level stays 4, overflow_cnt unchanged.
REQ-035 Parity and saturation: push 300 bytes with perr=1 while draining -> perr_cnt=255; a presented byte with perr=1 shows cpu_parity=1.
REQ-036 Reset mid-operation: assert reset in WAIT_REL with 2 bytes queued -> all outputs 0; with cpu_ack held high the FSM stays IDLE, and cpu_ack low plus a new push restarts normally.
